// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin owner of the 4-source bus mux SEL, with bounded hold
//            and one idle turnaround cycle between owners.
// Revision : 1.0
// ============================================================================
module bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_found;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic             w_release;

  // Cyclic search starting one past the last owner; i=4 wraps back to last_q.
  always_comb begin
    w_found = 1'b0;
    w_win   = last_q;
    w_idx   = last_q;
    for (int i = 1; i <= 4; i++) begin
      w_idx = last_q + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // In GRANT, sel_q always names the current owner.
  assign w_release = !req[sel_q] || done || (cnt_q == c_hold_last);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << w_win;
          sel_d   = w_win;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          last_d  = sel_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Scoreboard bench for bus_arbiter (MAX_HOLD=8 and MAX_HOLD=3).
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req8, req3;
  logic       done8, done3;
  logic [3:0] gnt8, gnt3;
  logic [1:0] sel8, sel3;
  logic       busy8, busy3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         id;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    string      nm;
  } exp_t;

  exp_t sb_q[$];

  bus_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .done(done8),
    .gnt(gnt8), .sel(sel8), .busy(busy8)
  );

  bus_arbiter #(.MAX_HOLD(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .done(done3),
    .gnt(gnt3), .sel(sel3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] ag, input logic [1:0] as_,
                     input logic ab, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb);
    checks++;
    if (ag !== eg || as_ !== es || ab !== eb) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b busy=%b",
               nm, ag, as_, ab, eg, es, eb);
    end
  endtask

  // Monitor: one expected entry per active edge, compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.id == 1'b0) chk(e.nm, gnt8, sel8, busy8, e.g, e.s, e.b);
        else              chk(e.nm, gnt3, sel3, busy3, e.g, e.s, e.b);
      end
    end
  end

  // Called at a falling edge: drive inputs, queue the outputs expected after
  // the next rising edge, then advance to the following falling edge.
  task automatic step(input logic [3:0] r8, input logic d8, input logic [3:0] r3,
                      input logic d3, input bit id, input logic [3:0] eg,
                      input logic [1:0] es, input logic eb, input string nm);
    exp_t e;
    req8 = r8; done8 = d8; req3 = r3; done3 = d3;
    e.id = id; e.g = eg; e.s = es; e.b = eb; e.nm = nm;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic reset_chk(input string nm);
    chk({nm, "_d8"}, gnt8, sel8, busy8, 4'b0000, 2'b00, 1'b0);
    chk({nm, "_d3"}, gnt3, sel3, busy3, 4'b0000, 2'b00, 1'b0);
  endtask

  initial begin
    int ph;
    int g;
    rst_n = 1'b0;
    req8 = 4'($urandom); done8 = 1'($urandom);
    req3 = 4'($urandom); done3 = 1'($urandom);
    #2;
    reset_chk("rst_noclk");
    req8 = 4'($urandom); done8 = 1'($urandom);
    req3 = 4'($urandom); done3 = 1'($urandom);
    #1;
    reset_chk("rst_noclk2");
    @(negedge clk);
    reset_chk("rst_clk");
    req8 = 4'b0000; done8 = 1'b0; req3 = 4'b0000; done3 = 1'b0;
    rst_n = 1'b1;

    // Hold limit: 8 grant cycles then exactly one idle, repeating.
    for (int e = 1; e <= 30; e++) begin
      ph = (e - 1) % 9;
      step(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0,
           (ph < 8) ? 4'b0100 : 4'b0000, 2'd2, (ph < 8), "hold8");
    end
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, "rel_drop");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, "idle_done");

    rst_n = 1'b0;
    #1;
    reset_chk("rst_idle");
    @(negedge clk);
    rst_n = 1'b1;

    // All requesting, DONE in second grant cycle: 0,1,2,3,0.
    for (int e = 1; e <= 15; e++) begin
      ph = (e - 1) % 3;
      g  = ((e - 1) / 3) % 4;
      step(4'b1111, (ph == 2), 4'b0000, 1'b0, 1'b0,
           (ph < 2) ? (4'b0001 << g) : 4'b0000, 2'(g), (ph < 2), "rr");
    end

    step(4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, "t4_grant1");
    step(4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, "t4_rel");
    step(4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, "t4_grant3");
    step(4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, "t4_hold");

    // Asynchronous reset in the middle of a grant to source 3.
    #2;
    rst_n = 1'b0;
    #1;
    reset_chk("rst_midgrant");
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, "t5_first");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, "t5_rel");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, "t5_idle_done");

    // MAX_HOLD=3: DONE coincides with the counter limit.
    step(4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, "t6_g1");
    step(4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, "t6_g2");
    step(4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, "t6_g3");
    step(4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, "t6_rel");
    step(4'b0000, 1'b0, 4'b0011, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, "t6_next");
    step(4'b0000, 1'b0, 4'b0011, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, "t6_h2");
    step(4'b0000, 1'b0, 4'b0011, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, "t6_h3");
    step(4'b0000, 1'b0, 4'b0011, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0, "t6_limit");
    step(4'b0000, 1'b0, 4'b0011, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, "t6_wrap");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter that owns the SEL input of the 4-source 16-bit bus multiplexer. It decides which of sources D0..D3 drives DBUS. It accepts per-source requests, issues one-hot grants, and drives the matching 2-bit select. It enforces a bounded hold time and a one-cycle turnaround between owners.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one source may hold the bus (legal range 1..2**CNT_W)
CNT_W, 4, width of the hold counter

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST_N  input  1  asynchronous, active-low reset
REQ  input  4  REQ[i]=1: source Di requests the bus; level-sensitive, held by the requester until done
DONE  input  1  owner releases the bus early; sampled only in GRANT
GNT  output  4  one-hot grant, registered; all zeros when no owner
SEL  output  2  binary index of the current or last owner; drives the bus mux SEL; registered
BUSY  output  1  1 while a grant is active (equals |GNT)

Behaviour:
- Reset (RST_N=0, asynchronous, regardless of CLK):
  - state=IDLE, GNT=4'b0000, SEL=2'b00, BUSY=0.
  - Hold counter=0. Priority pointer LAST=2'd3, so the first search starts at source 0.
- All outputs are registered. There is no combinational path from REQ or DONE to any output.
- States: IDLE, GRANT.
- IDLE:
  - If REQ==0, remain in IDLE; outputs hold and SEL keeps its last value.
  - Otherwise, search REQ cyclically starting at (LAST+1) mod 4. The first set bit k wins.
  - Next edge: GNT=one-hot(k), SEL=k, BUSY=1, counter=0, state=GRANT.
  - Latency from REQ sampled high to GNT high is 1 cycle.
- GRANT (owner k):
  - Evaluated at each edge. Release if any of the following holds:
    - (a) REQ[k]==0
    - (b) DONE==1
    - (c) counter==MAX_HOLD-1
  - On release: GNT=0, BUSY=0, LAST=k, counter=0, state=IDLE. SEL holds k.
  - Otherwise: counter increments and all outputs hold.
  - GNT therefore stays high for at most MAX_HOLD cycles.
  - Simultaneous release causes count as a single release; no double update of LAST.
- Turnaround: after every release the arbiter spends at least one IDLE cycle with GNT=0 before any new grant. This applies even when the same source is the only requester.
- Requests from non-owners during GRANT are ignored; they are evaluated only in IDLE.
- A requester that drops REQ before being granted is simply not selected. No request is latched.
- Fairness: a continuously requesting source waits for at most 3 other grants.
- Counter width rule: the comparison uses MAX_HOLD-1 truncated to CNT_W bits. MAX_HOLD outside 1..2**CNT_W is illegal configuration.
- Reset mid-grant: GNT and BUSY clear immediately, LAST returns to 3, and the next grant follows the post-reset order.
- DONE or REQ changes while in IDLE with REQ==0 have no effect.

Test Plan:
1. Reset: hold RST_N=0 with random REQ/DONE -> GNT=0000, SEL=00, BUSY=0 throughout, with no clock edge required.
2. MAX_HOLD=8: REQ=0100 held for 30 cycles, DONE=0 ->
   - one cycle after REQ: GNT=0100, SEL=10, BUSY=1
   - GNT high exactly 8 cycles, then exactly 1 cycle with GNT=0000
   - then re-granted to source 2; the pattern repeats.
3. REQ=1111 constant, DONE pulsed in the 2nd cycle of each grant -> grant order 0,1,2,3,0 with SEL 00,01,10,11,00. Each grant lasts 2 cycles, separated by 1 idle cycle.
4. REQ=1011, owner 1 granted, then REQ changes to 1001 -> GNT=0000 on the next edge, then GNT=1000 and SEL=11 (search starts at 2; 2 is not requesting, so 3 wins).
5. RST_N pulsed low during a grant to source 3 -> GNT=0000 and BUSY=0 immediately. After RST_N=1 with REQ=1100, the first grant goes to source 2 (SEL=10).
6. MAX_HOLD=3, owner 0 asserts DONE on the same edge the counter reaches 2 -> a single release, one idle cycle, LAST=0, next grant to source 1 when REQ=0011.
